// File: rtl/csc_coef_ctrl_pkg.sv
// Shared constants, state encoding and default BT.601 table for the
// colour-space-conversion coefficient controller.
package csc_coef_pkg;

    localparam int COEF_W     = 18;
    localparam int OFFS_W     = 11;
    localparam int COEF_COUNT = 9;
    localparam int OFFS_COUNT = 3;

    localparam logic [3:0] ADDR_OFFS_BASE = 4'd9;
    localparam logic [3:0] ADDR_LAST      = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESET  = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    // Offsets are returned zero-extended so one table serves both banks.
    function automatic logic [COEF_W-1:0] default_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return 18'h09916;
            4'd1:    return 18'h12C8B;
            4'd2:    return 18'h03A5E;
            4'd3:    return 18'h3A99B;
            4'd4:    return 18'h35664;
            4'd5:    return 18'h10000;
            4'd6:    return 18'h10000;
            4'd7:    return 18'h329A1;
            4'd8:    return 18'h3D65E;
            4'd9:    return 18'h00000;
            4'd10:   return 18'h00080;
            4'd11:   return 18'h00080;
            default: return 18'h00000;
        endcase
    endfunction

endpackage

// File: rtl/csc_coef_ctrl_if.sv
// Host configuration bus of the coefficient controller.
interface csc_coef_ctrl_if;
    import csc_coef_pkg::*;

    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic [COEF_W-1:0] cfg_wdata;
    logic              cfg_commit;
    logic              cfg_preset;
    logic              cfg_ready;
    logic              commit_pending;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, cfg_commit, cfg_preset,
        input  cfg_ready, commit_pending
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, cfg_commit, cfg_preset,
        output cfg_ready, commit_pending
    );

endinterface

// File: rtl/csc_coef_rom.sv
// Combinational 12x18 default-value ROM walked by the preset sequencer.
module csc_coef_rom
    import csc_coef_pkg::*;
(
    input  logic [3:0]        addr,
    output logic [COEF_W-1:0] data
);

    assign data = default_entry(addr);

endmodule

// File: rtl/csc_coef_ctrl.sv
// Shadow/active coefficient banks with frame-synchronous atomic commit
// and a ROM preset sequencer.
module csc_coef_ctrl
    import csc_coef_pkg::*;
#(
    parameter bit VSYNC_POL = 1'b1,
    parameter int NCOEF     = COEF_COUNT,
    parameter int NOFFS     = OFFS_COUNT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    in_vsync,
    csc_coef_ctrl_if.slave          cfg,
    output logic                    frame_updated,
    output logic [NCOEF*COEF_W-1:0] coef_out,
    output logic [NOFFS*OFFS_W-1:0] offs_out
);

    state_t            state, next_state;
    logic [3:0]        counter;
    logic              vs_q;
    logic              frame_edge;
    logic              apply;
    logic              sh_we;
    logic [3:0]        sh_addr;
    logic [COEF_W-1:0] sh_data;
    logic [COEF_W-1:0] rom_data;

    logic [COEF_W-1:0] shadow_coef [NCOEF];
    logic [COEF_W-1:0] active_coef [NCOEF];
    logic [OFFS_W-1:0] shadow_offs [NOFFS];
    logic [OFFS_W-1:0] active_offs [NOFFS];

    csc_coef_rom u_rom (
        .addr (counter),
        .data (rom_data)
    );

    // History resets to the active level so a vsync held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q <= VSYNC_POL;
        end else if (ce) begin
            vs_q <= in_vsync;
        end
    end

    assign frame_edge = ce && (in_vsync == VSYNC_POL) && (vs_q != VSYNC_POL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            counter <= '0;
        end else begin
            state   <= next_state;
            counter <= (state == ST_PRESET) ? counter + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        next_state = state;
        sh_we      = 1'b0;
        sh_addr    = cfg.cfg_addr;
        sh_data    = cfg.cfg_wdata;
        apply      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg.cfg_preset) begin
                    next_state = ST_PRESET;
                end else begin
                    sh_we = cfg.cfg_we;
                    if (cfg.cfg_commit) begin
                        next_state = ST_PENDING;
                    end
                end
            end
            ST_PRESET: begin
                sh_we   = 1'b1;
                sh_addr = counter;
                sh_data = rom_data;
                if (counter == ADDR_LAST) begin
                    next_state = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_edge) begin
                    apply      = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Addresses past the last offset match no entry and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCOEF; k++) begin
                shadow_coef[k] <= default_entry(4'(k));
                active_coef[k] <= default_entry(4'(k));
            end
            for (int j = 0; j < NOFFS; j++) begin
                shadow_offs[j] <= OFFS_W'(default_entry(ADDR_OFFS_BASE + 4'(j)));
                active_offs[j] <= OFFS_W'(default_entry(ADDR_OFFS_BASE + 4'(j)));
            end
        end else begin
            if (sh_we) begin
                for (int k = 0; k < NCOEF; k++) begin
                    if (sh_addr == 4'(k)) begin
                        shadow_coef[k] <= sh_data;
                    end
                end
                for (int j = 0; j < NOFFS; j++) begin
                    if (sh_addr == ADDR_OFFS_BASE + 4'(j)) begin
                        shadow_offs[j] <= OFFS_W'(sh_data);
                    end
                end
            end
            if (apply) begin
                for (int k = 0; k < NCOEF; k++) begin
                    active_coef[k] <= shadow_coef[k];
                end
                for (int j = 0; j < NOFFS; j++) begin
                    active_offs[j] <= shadow_offs[j];
                end
            end
        end
    end

    assign frame_updated      = apply && !rst;
    assign cfg.cfg_ready      = (state == ST_IDLE);
    assign cfg.commit_pending = (state == ST_PENDING);

    always_comb begin
        coef_out = '0;
        offs_out = '0;
        for (int k = 0; k < NCOEF; k++) begin
            coef_out[k*COEF_W +: COEF_W] = active_coef[k];
        end
        for (int j = 0; j < NOFFS; j++) begin
            offs_out[j*OFFS_W +: OFFS_W] = active_offs[j];
        end
    end

endmodule

// File: tb/tb_csc_coef_ctrl.sv
// Scenario bench for csc_coef_ctrl against a bank-level reference model.
module tb_csc_coef_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         ce;
    logic         in_vsync;
    logic         frame_updated;
    logic [161:0] coef_out;
    logic [32:0]  offs_out;

    int total = 0;
    int bad = 0;
    int fu_count = 0;

    logic [17:0] dflt     [12];
    logic [17:0] m_shadow [12];
    logic [17:0] m_active [12];

    csc_coef_ctrl_if cfg_bus ();

    csc_coef_ctrl #(
        .VSYNC_POL (1'b1),
        .NCOEF     (9),
        .NOFFS     (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .in_vsync      (in_vsync),
        .cfg           (cfg_bus),
        .frame_updated (frame_updated),
        .coef_out      (coef_out),
        .offs_out      (offs_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_updated === 1'b1) fu_count++;
    end

    function automatic logic [161:0] exp_coef();
        logic [161:0] v;
        for (int k = 0; k < 9; k++) v[18*k +: 18] = m_active[k];
        return v;
    endfunction

    function automatic logic [32:0] exp_offs();
        logic [32:0] v;
        for (int j = 0; j < 3; j++) v[11*j +: 11] = m_active[9+j][10:0];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [17:0] d);
        cfg_bus.cfg_we    = 1'b1;
        cfg_bus.cfg_addr  = a;
        cfg_bus.cfg_wdata = d;
        step();
        cfg_bus.cfg_we = 1'b0;
        if (a < 4'd9) m_shadow[a] = d;
        else if (a < 4'd12) m_shadow[a] = {7'b0, d[10:0]};
    endtask

    task automatic host_commit();
        cfg_bus.cfg_commit = 1'b1;
        step();
        cfg_bus.cfg_commit = 1'b0;
    endtask

    // Leaves the current cycle holding a rising vsync edge.
    task automatic vs_rise();
        in_vsync = 1'b0;
        step();
        in_vsync = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        m_shadow = dflt;
        m_active = dflt;
    endtask

    task automatic test_reset();
        int fu0;
        in_vsync = 1'b1;
        do_reset();
        repeat (3) step();
        @(negedge clk);
        total++; if (cfg_bus.cfg_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got %b want 1", cfg_bus.cfg_ready); end
        total++; if (cfg_bus.commit_pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_pending got %b want 0", cfg_bus.commit_pending); end
        total++; if (coef_out[17:0] !== 18'h09916) begin bad++; $display("[TB] FAIL reset_coef0 got %h want 09916", coef_out[17:0]); end
        total++; if (offs_out[21:11] !== 11'h080) begin bad++; $display("[TB] FAIL reset_offs1 got %h want 080", offs_out[21:11]); end
        total++; if (coef_out !== exp_coef()) begin bad++; $display("[TB] FAIL reset_coef got %h want %h", coef_out, exp_coef()); end
        total++; if (offs_out !== exp_offs()) begin bad++; $display("[TB] FAIL reset_offs got %h want %h", offs_out, exp_offs()); end
        step();
        fu0 = fu_count;
        host_commit();
        repeat (4) step();
        total++; if (fu_count - fu0 !== 0) begin bad++; $display("[TB] FAIL reset_no_edge got %0d pulses want 0", fu_count - fu0); end
        @(negedge clk);
        total++; if (cfg_bus.commit_pending !== 1'b1) begin bad++; $display("[TB] FAIL reset_hold_pending got %b want 1", cfg_bus.commit_pending); end
        vs_rise();
        @(negedge clk);
        total++; if (frame_updated !== 1'b1) begin bad++; $display("[TB] FAIL reset_first_edge got %b want 1", frame_updated); end
        step();
        total++; if (fu_count - fu0 !== 1) begin bad++; $display("[TB] FAIL reset_pulse_count got %0d want 1", fu_count - fu0); end
    endtask

    task automatic test_write_commit();
        int fu0;
        for (int i = 0; i < 6; i++) host_write(4'($urandom_range(0, 15)), 18'($urandom));
        host_write(4'd0, 18'h12345);
        host_write(4'd10, 18'h3F7FF);
        for (int a = 12; a < 16; a++) host_write(4'(a), 18'($urandom));
        @(negedge clk);
        total++; if (cfg_bus.cfg_ready !== 1'b1) begin bad++; $display("[TB] FAIL unused_addr_ready got %b want 1", cfg_bus.cfg_ready); end
        step();
        fu0 = fu_count;
        host_commit();
        repeat (3) step();
        @(negedge clk);
        total++; if (cfg_bus.commit_pending !== 1'b1 || cfg_bus.cfg_ready !== 1'b0) begin bad++; $display("[TB] FAIL wc_pending got %b/%b want 1/0", cfg_bus.commit_pending, cfg_bus.cfg_ready); end
        total++; if (coef_out !== exp_coef()) begin bad++; $display("[TB] FAIL wc_hold_coef got %h want %h", coef_out, exp_coef()); end
        vs_rise();
        @(negedge clk);
        total++; if (frame_updated !== 1'b1) begin bad++; $display("[TB] FAIL wc_pulse got %b want 1", frame_updated); end
        step();
        m_active = m_shadow;
        total++; if (fu_count - fu0 !== 1) begin bad++; $display("[TB] FAIL wc_pulse_count got %0d want 1", fu_count - fu0); end
        @(negedge clk);
        total++; if (coef_out[17:0] !== 18'h12345) begin bad++; $display("[TB] FAIL wc_coef0 got %h want 12345", coef_out[17:0]); end
        total++; if (offs_out[21:11] !== 11'h7FF) begin bad++; $display("[TB] FAIL wc_offs1 got %h want 7ff", offs_out[21:11]); end
        total++; if (coef_out !== exp_coef()) begin bad++; $display("[TB] FAIL wc_coef got %h want %h", coef_out, exp_coef()); end
        total++; if (offs_out !== exp_offs()) begin bad++; $display("[TB] FAIL wc_offs got %h want %h", offs_out, exp_offs()); end
        total++; if (cfg_bus.commit_pending !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin bad++; $display("[TB] FAIL wc_idle got %b/%b want 0/1", cfg_bus.commit_pending, cfg_bus.cfg_ready); end
    endtask

    task automatic test_pending_ignore();
        logic [17:0] d;
        host_write(4'd1, 18'h12C8B);
        d = 18'($urandom);
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = 4'd2; cfg_bus.cfg_wdata = d; cfg_bus.cfg_commit = 1'b1;
        step();
        cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_commit = 1'b0;
        m_shadow[2] = d;
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = 4'd1; cfg_bus.cfg_wdata = 18'h00001;
        step();
        cfg_bus.cfg_we = 1'b0;
        cfg_bus.cfg_preset = 1'b1; step(); cfg_bus.cfg_preset = 1'b0;
        cfg_bus.cfg_commit = 1'b1; step(); cfg_bus.cfg_commit = 1'b0;
        vs_rise();
        @(negedge clk);
        total++; if (frame_updated !== 1'b1) begin bad++; $display("[TB] FAIL pi_pulse got %b want 1", frame_updated); end
        step();
        m_active = m_shadow;
        repeat (2) step();
        @(negedge clk);
        total++; if (coef_out[35:18] !== 18'h12C8B) begin bad++; $display("[TB] FAIL pi_coef1 got %h want 12c8b", coef_out[35:18]); end
        total++; if (coef_out !== exp_coef()) begin bad++; $display("[TB] FAIL pi_coef got %h want %h", coef_out, exp_coef()); end
        total++; if (cfg_bus.cfg_ready !== 1'b1) begin bad++; $display("[TB] FAIL pi_ready got %b want 1", cfg_bus.cfg_ready); end
    endtask

    task automatic test_ce_gate();
        int fu0;
        host_write(4'($urandom_range(0, 11)), 18'($urandom));
        fu0 = fu_count;
        host_commit();
        ce = 1'b0;
        in_vsync = 1'b0; step();
        in_vsync = 1'b1; repeat (2) step();
        ce = 1'b1;
        repeat (2) step();
        total++; if (fu_count - fu0 !== 0) begin bad++; $display("[TB] FAIL ce_gated_edge got %0d pulses want 0", fu_count - fu0); end
        @(negedge clk);
        total++; if (cfg_bus.commit_pending !== 1'b1) begin bad++; $display("[TB] FAIL ce_still_pending got %b want 1", cfg_bus.commit_pending); end
        vs_rise();
        @(negedge clk);
        total++; if (frame_updated !== 1'b1) begin bad++; $display("[TB] FAIL ce_apply got %b want 1", frame_updated); end
        step();
        m_active = m_shadow;
        @(negedge clk);
        total++; if (coef_out !== exp_coef() || offs_out !== exp_offs()) begin bad++; $display("[TB] FAIL ce_bank got %h/%h want %h/%h", coef_out, offs_out, exp_coef(), exp_offs()); end
    endtask

    task automatic test_commit_timing();
        host_write(4'($urandom_range(0, 11)), 18'($urandom));
        in_vsync = 1'b0; step();
        cfg_bus.cfg_commit = 1'b1; in_vsync = 1'b1;
        @(negedge clk);
        total++; if (frame_updated !== 1'b0) begin bad++; $display("[TB] FAIL ct_same_cycle got %b want 0", frame_updated); end
        step();
        cfg_bus.cfg_commit = 1'b0;
        step();
        @(negedge clk);
        total++; if (cfg_bus.commit_pending !== 1'b1) begin bad++; $display("[TB] FAIL ct_edge_unused got %b want 1", cfg_bus.commit_pending); end
        vs_rise();
        @(negedge clk);
        total++; if (frame_updated !== 1'b1) begin bad++; $display("[TB] FAIL ct_next_edge got %b want 1", frame_updated); end
        step();
        m_active = m_shadow;
        host_write(4'($urandom_range(0, 11)), 18'($urandom));
        in_vsync = 1'b0;
        cfg_bus.cfg_commit = 1'b1;
        step();
        cfg_bus.cfg_commit = 1'b0;
        in_vsync = 1'b1;
        @(negedge clk);
        total++; if (frame_updated !== 1'b1) begin bad++; $display("[TB] FAIL ct_t_plus_1 got %b want 1", frame_updated); end
        step();
        m_active = m_shadow;
        @(negedge clk);
        total++; if (coef_out !== exp_coef() || offs_out !== exp_offs()) begin bad++; $display("[TB] FAIL ct_bank got %h/%h want %h/%h", coef_out, offs_out, exp_coef(), exp_offs()); end
    endtask

    task automatic test_preset();
        int low_cycles;
        int held;
        for (int i = 0; i < 4; i++) host_write(4'($urandom_range(0, 11)), 18'($urandom));
        in_vsync = 1'b0; step();
        cfg_bus.cfg_preset = 1'b1; cfg_bus.cfg_commit = 1'b1;
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = 4'd3; cfg_bus.cfg_wdata = 18'($urandom);
        step();
        cfg_bus.cfg_preset = 1'b0; cfg_bus.cfg_commit = 1'b0; cfg_bus.cfg_we = 1'b0;
        low_cycles = 0;
        held = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cfg_bus.cfg_ready === 1'b0 && cfg_bus.commit_pending === 1'b0) low_cycles++;
            if (coef_out === exp_coef()) held++;
            step();
        end
        total++; if (low_cycles !== 12) begin bad++; $display("[TB] FAIL preset_busy got %0d cycles want 12", low_cycles); end
        total++; if (held !== 12) begin bad++; $display("[TB] FAIL preset_active_held got %0d cycles want 12", held); end
        in_vsync = 1'b1;
        @(negedge clk);
        total++; if (cfg_bus.commit_pending !== 1'b1) begin bad++; $display("[TB] FAIL preset_pending got %b want 1", cfg_bus.commit_pending); end
        total++; if (frame_updated !== 1'b1) begin bad++; $display("[TB] FAIL preset_t_plus_13 got %b want 1", frame_updated); end
        step();
        m_shadow = dflt;
        m_active = dflt;
        @(negedge clk);
        total++; if (coef_out !== exp_coef() || offs_out !== exp_offs()) begin bad++; $display("[TB] FAIL preset_defaults got %h/%h want %h/%h", coef_out, offs_out, exp_coef(), exp_offs()); end
    endtask

    task automatic test_reset_mid_preset();
        int fu0;
        host_write(4'd0, 18'h2AAAA);
        host_write(4'd11, 18'h00555);
        host_commit();
        vs_rise(); step();
        m_active = m_shadow;
        in_vsync = 1'b0; step();
        cfg_bus.cfg_preset = 1'b1; step(); cfg_bus.cfg_preset = 1'b0;
        repeat (5) step();
        rst = 1'b1; step(); rst = 1'b0;
        m_shadow = dflt;
        m_active = dflt;
        @(negedge clk);
        total++; if (cfg_bus.cfg_ready !== 1'b1 || cfg_bus.commit_pending !== 1'b0) begin bad++; $display("[TB] FAIL rmp_state got %b/%b want 1/0", cfg_bus.cfg_ready, cfg_bus.commit_pending); end
        total++; if (coef_out !== exp_coef() || offs_out !== exp_offs()) begin bad++; $display("[TB] FAIL rmp_active got %h/%h want %h/%h", coef_out, offs_out, exp_coef(), exp_offs()); end
        step();
        fu0 = fu_count;
        vs_rise(); repeat (3) step();
        total++; if (fu_count - fu0 !== 0) begin bad++; $display("[TB] FAIL rmp_no_update got %0d pulses want 0", fu_count - fu0); end
        host_commit();
        vs_rise(); step();
        @(negedge clk);
        total++; if (coef_out !== exp_coef() || offs_out !== exp_offs()) begin bad++; $display("[TB] FAIL rmp_shadow_defaults got %h/%h want %h/%h", coef_out, offs_out, exp_coef(), exp_offs()); end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 8; it++) begin
            int nw;
            nw = (it == 0) ? 0 : int'($urandom_range(1, 4));
            for (int w = 0; w < nw; w++) host_write(4'($urandom_range(0, 15)), 18'($urandom));
            host_commit();
            vs_rise();
            @(negedge clk);
            total++; if (frame_updated !== 1'b1) begin bad++; $display("[TB] FAIL b2b_pulse[%0d] got %b want 1", it, frame_updated); end
            step();
            m_active = m_shadow;
            @(negedge clk);
            total++; if (coef_out !== exp_coef() || offs_out !== exp_offs()) begin bad++; $display("[TB] FAIL b2b_bank[%0d] got %h/%h want %h/%h", it, coef_out, offs_out, exp_coef(), exp_offs()); end
        end
    endtask

    initial begin
        dflt = '{18'h09916, 18'h12C8B, 18'h03A5E, 18'h3A99B, 18'h35664, 18'h10000,
                 18'h10000, 18'h329A1, 18'h3D65E, 18'h00000, 18'h00080, 18'h00080};
        m_shadow = dflt;
        m_active = dflt;
        rst = 1'b1;
        ce = 1'b1;
        in_vsync = 1'b1;
        cfg_bus.cfg_we = 1'b0;
        cfg_bus.cfg_addr = 4'd0;
        cfg_bus.cfg_wdata = 18'd0;
        cfg_bus.cfg_commit = 1'b0;
        cfg_bus.cfg_preset = 1'b0;
        test_reset();
        test_write_commit();
        test_pending_ignore();
        test_ce_gate();
        test_commit_timing();
        test_preset();
        test_reset_mid_preset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
